// File: rtl/light_ramp_ctrl.sv
// light_ramp_ctrl: configurable triangle brightness ramp with PWM drive; LRC_HOLD_EN adds dwell at peak and zero.
module light_ramp_ctrl #(
    parameter int M          = 10,
    parameter int N          = 10,
    parameter int CYCLES     = 1,
    parameter int HOLD_STEPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        cfg_we,
    input  logic [31:0] cfg_period,
    input  logic [31:0] cfg_peak,
    input  logic [7:0]  cfg_cycles,
    output logic [31:0] level,
    output logic        pwm_out,
    output logic        dir,
    output logic        busy,
    output logic        done
);
`ifdef LRC_HOLD_EN
    typedef enum logic [2:0] {IDLE, RISE, FALL, DONE, HOLD_HI, HOLD_LO} state_t;
    localparam bit HOLD = HOLD_STEPS != 0;
    logic [31:0] hold_cnt, hold_n;
`else
    typedef enum logic [1:0] {IDLE, RISE, FALL, DONE} state_t;
`endif
    state_t state, state_n;
    logic [31:0] period, period_n, peak, peak_n, tick, tick_n, pwm_cnt, pwm_n, level_n;
    logic [7:0]  cycles, cycles_n, breaths, breaths_n;
    logic        step, last_breath;
    always_comb begin
        state_n     = state;
        period_n    = period;
        peak_n      = peak;
        cycles_n    = cycles;
        tick_n      = 32'd0;
        level_n     = level;
        breaths_n   = breaths;
        step        = tick == period;
        last_breath = cycles != 8'd0 && breaths + 8'd1 == cycles;
`ifdef LRC_HOLD_EN
        hold_n      = 32'd0;
`endif
        if (state == IDLE) begin
            if (cfg_we) begin
                period_n = cfg_period;
                peak_n   = cfg_peak;
                cycles_n = cfg_cycles;
            end
            if (start) begin
                level_n   = 32'd0;
                breaths_n = 8'd0;
                state_n   = (cfg_we ? cfg_peak : peak) == 32'd0 ? DONE : RISE;
            end
        end else if (stop) begin
            state_n   = IDLE;
            level_n   = 32'd0;
            breaths_n = 8'd0;
        end else begin
            tick_n = step ? 32'd0 : tick + 32'd1;
            case (state)
                RISE: if (step) begin
                    level_n = level + 32'd1;
`ifdef LRC_HOLD_EN
                    if (level_n == peak) state_n = HOLD ? HOLD_HI : FALL;
`else
                    if (level_n == peak) state_n = FALL;
`endif
                end
                FALL: if (step) begin
                    level_n = level - 32'd1;
                    if (level_n == 32'd0) begin
                        breaths_n = cycles != 8'd0 ? breaths + 8'd1 : breaths;
`ifdef LRC_HOLD_EN
                        state_n = last_breath ? DONE : HOLD ? HOLD_LO : RISE;
`else
                        state_n = last_breath ? DONE : RISE;
`endif
                    end
                end
`ifdef LRC_HOLD_EN
                HOLD_HI, HOLD_LO: begin
                    hold_n = step ? hold_cnt + 32'd1 : hold_cnt;
                    if (hold_n == 32'(HOLD_STEPS)) begin
                        hold_n  = 32'd0;
                        state_n = state == HOLD_HI ? FALL : RISE;
                    end
                end
`endif
                DONE: begin
                    state_n   = IDLE;
                    tick_n    = 32'd0;
                    level_n   = 32'd0;
                    breaths_n = 8'd0;
                end
                default: state_n = IDLE;
            endcase
        end
        // PWM counter restarts from 0 on the first busy cycle and wraps at peak
        pwm_n = busy && state_n != IDLE && pwm_cnt + 32'd1 < peak ? pwm_cnt + 32'd1 : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            period  <= 32'(M);
            peak    <= 32'(N);
            cycles  <= 8'(CYCLES);
            tick    <= 32'd0;
            pwm_cnt <= 32'd0;
            breaths <= 8'd0;
            level   <= 32'd0;
            pwm_out <= 1'b0;
            dir     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef LRC_HOLD_EN
            hold_cnt <= 32'd0;
`endif
        end else begin
            state   <= state_n;
            period  <= period_n;
            peak    <= peak_n;
            cycles  <= cycles_n;
            tick    <= tick_n;
            pwm_cnt <= pwm_n;
            breaths <= breaths_n;
            level   <= level_n;
            pwm_out <= state_n != IDLE && pwm_n < level_n;
            busy    <= state_n != IDLE;
            done    <= state_n == DONE;
`ifdef LRC_HOLD_EN
            dir      <= state_n == RISE || state_n == HOLD_HI;
            hold_cnt <= hold_n;
`else
            dir      <= state_n == RISE;
`endif
        end
    end
endmodule
